prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ROM_SIZE, default 16, instruction-memory address width in bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begins a load when sampled high in IDLE, DONE or ERR.
REQ-005 byte_in  input  8  incoming load-stream byte.
REQ-006 byte_valid  input  1  byte_in is valid this cycle.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-008 rom_we  output  1  instruction-memory write strobe.
REQ-009 rom_addr  output  ROM_SIZE  instruction-memory write address.
REQ-010 rom_data  output  16  instruction word to write.
REQ-011 cpu_rst  output  1  processor reset hold; high while no valid program is loaded.
REQ-012 done  output  1  load completed successfully.
REQ-013 error  output  1  load rejected (header too large).

Function
REQ-014 A byte SHALL be accepted only on a cycle with byte_valid=1 and byte_ready=1; other bytes are ignored.
REQ-015 Stream format SHALL be a 16-bit word count N (high byte first), then N instruction words, each high byte first.
REQ-016 States SHALL be IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, DONE, ERR; all outputs registered.
REQ-017 byte_ready SHALL be 1 exactly in HDR_HI, HDR_LO, DAT_HI, DAT_LO.
REQ-018 IDLE/DONE/ERR with start=1 -> HDR_HI; word index cleared to 0; done and error cleared; cpu_rst set to 1 on the same edge.
REQ-019 start SHALL be ignored in HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE.
REQ-020 HDR_HI on accept -> HDR_LO; HDR_LO on accept latches N.
REQ-021 In HDR_LO on accept: N=0 -> DONE; N > 2**ROM_SIZE (compared in ROM_SIZE+1 bits) -> ERR; otherwise -> DAT_HI.
REQ-022 DAT_HI on accept -> DAT_LO; DAT_LO on accept -> WRITE with rom_data={high byte, low byte} and rom_addr=word index.
REQ-023 In WRITE, rom_we SHALL be 1 for exactly one cycle; rom_we SHALL be 0 in every other state.
REQ-024 Write latency: rom_we high on the cycle immediately after the low byte is accepted.
REQ-025 On leaving WRITE the index SHALL increment; if the written index equalled N-1 -> DONE, else -> DAT_HI.
REQ-026 With N=2**ROM_SIZE the final write SHALL use address all-ones; the index SHALL never wrap during a load.
REQ-027 DONE: done=1, cpu_rst=0, held until start or rst.
REQ-028 ERR: error=1, cpu_rst=1, no writes, held until start or rst.
REQ-029 rom_addr and rom_data SHALL hold their last values outside WRITE.
REQ-030 byte_valid without byte_ready SHALL NOT change state or outputs.

Reset
REQ-031 rst=1 SHALL on the next edge force IDLE, byte_ready=0, rom_we=0, rom_addr=0, rom_data=0, cpu_rst=1, done=0, error=0, index=0, N=0.
REQ-032 rst SHALL take priority over start and byte acceptance in the same cycle.
REQ-033 rst mid-load SHALL abort with no further rom_we pulses; already-written words are not cleared.

Verification
REQ-034 Load bytes 00 02 12 34 AB CD (valid every cycle) -> writes 0x1234@0 and 0xABCD@1, one rom_we cycle each, then done=1, cpu_rst=0.
REQ-035 Header 00 00 -> DONE directly, no rom_we, done=1.
REQ-036 ROM_SIZE=4, header 00 11 (N=17) -> error=1, cpu_rst=1, byte_ready=0; header 00 10 with 16 words -> last write at address 0xF, done=1.
REQ-037 Load 00 01 BE EF with byte_valid toggled 1/0 each cycle -> single write 0xBEEF@0, state unchanged on invalid cycles.
REQ-038 rst asserted in DAT_LO after 1 of 3 words written -> outputs at reset values next edge, no further rom_we; new start reloads from address 0.
REQ-039 start pulsed during DAT_HI -> ignored; start in DONE -> cpu_rst=1 and done=0 on the next edge, new load begins.

Source files
------------

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a byte stream and writes it into an instruction memory. The stream
// starts with a 16-bit word count N (high byte first), followed by N 16-bit
// instruction words (each high byte first). The processor is held in reset
// until a complete program has been written.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        begins a new load from IDLE, DONE or ERR
//   byte_in      incoming stream byte
//   byte_valid   byte_in carries data this cycle
//   byte_ready   loader takes byte_in this cycle (registered)
//   rom_we       one-cycle instruction-memory write strobe
//   rom_addr     instruction-memory write address (ROM_SIZE bits)
//   rom_data     instruction word to write
//   cpu_rst      processor reset hold, low only once a program is loaded
//   done         load finished successfully
//   error        load rejected because the header asked for too many words
// -----------------------------------------------------------------------------
module prog_loader #(
   parameter int ROM_SIZE = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [7:0]          byte_in,
   input  logic                byte_valid,
   output logic                byte_ready,
   output logic                rom_we,
   output logic [ROM_SIZE-1:0] rom_addr,
   output logic [15:0]         rom_data,
   output logic                cpu_rst,
   output logic                done,
   output logic                error
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] HDR_HI = 3'd1;
   localparam logic [2:0] HDR_LO = 3'd2;
   localparam logic [2:0] DAT_HI = 3'd3;
   localparam logic [2:0] DAT_LO = 3'd4;
   localparam logic [2:0] WRITE  = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;
   localparam logic [2:0] ERR    = 3'd7;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [7:0]        hi_byte;
   logic [15:0]       n_words;
   logic [ROM_SIZE:0] idx;
   logic [15:0]       hdr_word;
   logic              accept;
   logic              too_big;
   logic              last_word;

   // A byte is only consumed when both sides agree; byte_ready is registered
   // so it always reflects the current state.
   assign accept   = byte_valid & byte_ready;
   assign hdr_word = {hi_byte, byte_in};

   // The limit check is done in 32 bits so that 2**ROM_SIZE itself is always
   // representable, even when ROM_SIZE equals the 16-bit count width.
   assign too_big  = 32'(hdr_word) > (32'd1 << ROM_SIZE);

   // The index carries one extra bit so a full-size load never wraps; the
   // last word is the one whose index equals N-1.
   assign last_word = (32'(idx) + 32'd1) == 32'(n_words);

   // Next-state decision. Start is only honoured in the resting states, and
   // every streaming state advances only on an accepted byte.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: begin
            if (start) state_nxt = HDR_HI;
         end
         HDR_HI: begin
            if (accept) state_nxt = HDR_LO;
         end
         HDR_LO: begin
            if (accept) begin
               if (hdr_word == 16'd0) state_nxt = DONE;
               else if (too_big)      state_nxt = ERR;
               else                   state_nxt = DAT_HI;
            end
         end
         DAT_HI: begin
            if (accept) state_nxt = DAT_LO;
         end
         DAT_LO: begin
            if (accept) state_nxt = WRITE;
         end
         WRITE: begin
            state_nxt = last_word ? DONE : DAT_HI;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus all outputs. Status outputs are derived from the
   // next state so they line up with the state they describe; the memory
   // address/data are only loaded on the low data byte and otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         byte_ready <= 1'b0;
         rom_we     <= 1'b0;
         rom_addr   <= '0;
         rom_data   <= 16'd0;
         cpu_rst    <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         idx        <= '0;
         n_words    <= 16'd0;
         hi_byte    <= 8'd0;
      end else begin
         state      <= state_nxt;
         byte_ready <= (state_nxt == HDR_HI) || (state_nxt == HDR_LO) ||
                       (state_nxt == DAT_HI) || (state_nxt == DAT_LO);
         rom_we     <= (state_nxt == WRITE);
         done       <= (state_nxt == DONE);
         error      <= (state_nxt == ERR);
         cpu_rst    <= (state_nxt != DONE);

         case (state)
            IDLE, DONE, ERR: begin
               if (start) idx <= '0;
            end
            HDR_HI, DAT_HI: begin
               if (accept) hi_byte <= byte_in;
            end
            HDR_LO: begin
               if (accept) n_words <= hdr_word;
            end
            DAT_LO: begin
               if (accept) begin
                  rom_data <= hdr_word;
                  rom_addr <= idx[ROM_SIZE-1:0];
               end
            end
            WRITE: begin
               idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
